restador_serial: RTL and testbench

Bit-serial N-bit unsigned subtractor controller. It sequences a single one-bit full-subtract cell, built from two half-subtractor stages plus an OR on the borrows, over the operands LSB first. It uses a start/done handshake and a registered borrow. It sits beside the basic arithmetic cells as the low-area alternative to a ripple N-bit subtractor.

---
 rtl/restador_serial.sv | 134 +++++++++++++
 tb/tb_restador_serial.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/restador_serial.sv
// restador_serial: bit-serial unsigned subtractor, LSB first.
// One full-subtract cell is reused over N cycles under a start/done handshake.
module restador_medio (
   input  logic a,
   input  logic b,
   output logic r,
   output logic bo
);
   assign r  = a ^ b;
   assign bo = ~a & b;
endmodule

module restador_serial #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inicio,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] D,
   output logic         AN,
   output logic         ocupado,
   output logic         listo
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] ULT = CW'(N - 1);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      RESTA  = 2'd1,
      FIN    = 2'd2
   } estado_t;

   estado_t estado, estado_sig;

   logic [N-1:0]  sa, sb, sd, sd_sig;
   logic [CW-1:0] cnt;
   logic          br;
   logic          r1, b1, d, b2, borrow_sig;
   logic          cargar, desplazar, ultimo;

   // Full subtractor: two half-subtractor stages, borrows ORed.
   restador_medio u_etapa1 (
      .a  (sa[0]),
      .b  (sb[0]),
      .r  (r1),
      .bo (b1)
   );

   restador_medio u_etapa2 (
      .a  (r1),
      .b  (br),
      .r  (d),
      .bo (b2)
   );

   assign borrow_sig = b1 | b2;

   generate
      if (N == 1) begin : g_uno
         assign sd_sig = d;
      end else begin : g_n
         assign sd_sig = {d, sd[N-1:1]};
      end
   endgenerate

   always_comb begin
      estado_sig = estado;
      cargar     = 1'b0;
      desplazar  = 1'b0;
      ultimo     = 1'b0;
      unique case (estado)
         REPOSO: begin
            if (inicio) begin
               cargar     = 1'b1;
               estado_sig = RESTA;
            end
         end
         RESTA: begin
            desplazar = 1'b1;
            if (cnt == ULT) begin
               ultimo     = 1'b1;
               estado_sig = FIN;
            end
         end
         FIN: begin
            estado_sig = REPOSO;
         end
         default: begin
            estado_sig = REPOSO;
         end
      endcase
   end

   assign ocupado = (estado != REPOSO);
   assign listo   = (estado == FIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         estado <= REPOSO;
      end else begin
         estado <= estado_sig;
      end
   end

   // D/AN only change on the last bit edge, so partial sums never leak out.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa  <= '0;
         sb  <= '0;
         sd  <= '0;
         br  <= 1'b0;
         cnt <= '0;
         D   <= '0;
         AN  <= 1'b0;
      end else if (cargar) begin
         sa  <= A;
         sb  <= B;
         br  <= 1'b0;
         cnt <= '0;
      end else if (desplazar) begin
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         sd  <= sd_sig;
         br  <= borrow_sig;
         cnt <= ultimo ? '0 : cnt + 1'b1;
         if (ultimo) begin
            D  <= sd_sig;
            AN <= borrow_sig;
         end
      end
   end
endmodule

// File: tb/tb_restador_serial.sv
// Scoreboard bench for restador_serial at N=8, N=1 and N=16.
// Expected results come from plain modular arithmetic.
module tb_restador_serial;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic ini8, ini1, ini16;
   logic [7:0] a8, b8, d8;
   logic [0:0] a1, b1, d1;
   logic [15:0] a16, b16, d16;
   logic an8, oc8, li8;
   logic an1, oc1, li1;
   logic an16, oc16, li16;

   int total = 0;
   int bad = 0;
   int nli8 = 0;
   logic [8:0] q8[$];
   logic [1:0] q1[$];
   logic [16:0] q16[$];

   restador_serial #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .inicio(ini8), .A(a8), .B(b8),
      .D(d8), .AN(an8), .ocupado(oc8), .listo(li8)
   );
   restador_serial #(.N(1)) dut1 (
      .clk(clk), .rst(rst), .inicio(ini1), .A(a1), .B(b1),
      .D(d1), .AN(an1), .ocupado(oc1), .listo(li1)
   );
   restador_serial #(.N(16)) dut16 (
      .clk(clk), .rst(rst), .inicio(ini16), .A(a16), .B(b16),
      .D(d16), .AN(an16), .ocupado(oc16), .listo(li16)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b);
      int d;
      d = (int'(a) + 256 - int'(b)) % 256;
      return {a < b, 8'(d)};
   endfunction

   function automatic logic [1:0] ref1(input logic [0:0] a, input logic [0:0] b);
      int d;
      d = (int'(a) + 2 - int'(b)) % 2;
      return {a < b, 1'(d)};
   endfunction

   function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b);
      int d;
      d = (int'(a) + 65536 - int'(b)) % 65536;
      return {a < b, 16'(d)};
   endfunction

   always @(negedge clk) begin : mon8
      logic [8:0] e;
      if (li8) begin
         nli8++;
         if (q8.size() == 0) begin
            total++; bad++;
            $display("FAIL listo8: got unexpected pulse D=%0h expected none", d8);
         end else begin
            e = q8.pop_front();
            chk("d8", 32'(d8), 32'(e[7:0]));
            chk("an8", 32'(an8), 32'(e[8]));
         end
      end
   end

   always @(negedge clk) begin : mon1
      logic [1:0] e;
      if (li1) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL listo1: got unexpected pulse expected none");
         end else begin
            e = q1.pop_front();
            chk("d1", 32'(d1), 32'(e[0]));
            chk("an1", 32'(an1), 32'(e[1]));
         end
      end
   end

   always @(negedge clk) begin : mon16
      logic [16:0] e;
      if (li16) begin
         if (q16.size() == 0) begin
            total++; bad++;
            $display("FAIL listo16: got unexpected pulse expected none");
         end else begin
            e = q16.pop_front();
            chk("d16", 32'(d16), 32'(e[15:0]));
            chk("an16", 32'(an16), 32'(e[16]));
         end
      end
   end

   task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit push);
      @(negedge clk);
      a8 = a; b8 = b; ini8 = 1'b1;
      if (push) q8.push_back(ref8(a, b));
      @(posedge clk); #1;
      ini8 = 1'b0;
   endtask

   task automatic go1(input logic [0:0] a, input logic [0:0] b);
      @(negedge clk);
      a1 = a; b1 = b; ini1 = 1'b1;
      q1.push_back(ref1(a, b));
      @(posedge clk); #1;
      ini1 = 1'b0;
      a1 = ~a; b1 = 1'($urandom);
   endtask

   task automatic go16(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      a16 = a; b16 = b; ini16 = 1'b1;
      q16.push_back(ref16(a, b));
      @(posedge clk); #1;
      ini16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
   endtask

   task automatic wait_li(input int w, input string nm, output int lat);
      logic l;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         l = (w == 1) ? li1 : (w == 8) ? li8 : li16;
         if (l) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) begin
         total++; bad++;
         $display("FAIL %s: got no listo within 40 edges expected one", nm);
      end
   endtask

   initial begin : stim
      int lat, nb;
      int pk[$];
      logic [7:0] va[3], vb[3];
      va = '{8'h00, 8'hFF, 8'h80};
      vb = '{8'h01, 8'hFF, 8'h7F};

      rst = 1'b1;
      ini8 = 0; ini1 = 0; ini16 = 0;
      a8 = 0; b8 = 0; a1 = 0; b1 = 0; a16 = 0; b16 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_d", 32'(d8), 32'h0);
      chk("rst_an", 32'(an8), 32'h0);
      chk("rst_ocupado", 32'(oc8), 32'h0);
      chk("rst_listo", 32'(li8), 32'h0);
      @(negedge clk) rst = 1'b0;

      go8(8'h5A, 8'h3C, 1'b1);
      chk("ocupado_start", 32'(oc8), 32'h1);
      wait_li(8, "lat_basic", lat);
      chk("lat_basic", 32'(lat), 32'd8);
      @(posedge clk); #1;
      chk("ocupado_end", 32'(oc8), 32'h0);
      chk("listo_one_cycle", 32'(li8), 32'h0);

      for (int i = 0; i < 3; i++) begin
         go8(va[i], vb[i], 1'b1);
         wait_li(8, "lat_vec", lat);
         chk("lat_vec", 32'(lat), 32'd8);
         @(posedge clk); #1;
      end

      nb = nli8;
      go8(8'h10, 8'h01, 1'b1);
      lat = -1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom);
         ini8 = (k == 3);
         if (k == 3) begin
            a8 = 8'h00; b8 = 8'hFF;
         end
         @(posedge clk); #1;
         if (k == 4) chk("d_hold", 32'(d8), 32'h01);
         if (li8 && lat < 0) lat = k;
      end
      repeat (10) @(posedge clk);
      #1;
      chk("busy_lat", 32'(lat), 32'd8);
      chk("busy_pulses", 32'(nli8 - nb), 32'd1);

      go8(8'hF0, 8'h0F, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_d", 32'(d8), 32'h0);
      chk("mid_rst_an", 32'(an8), 32'h0);
      chk("mid_rst_ocupado", 32'(oc8), 32'h0);
      chk("mid_rst_listo", 32'(li8), 32'h0);
      @(negedge clk) rst = 1'b0;
      go8(8'h03, 8'h05, 1'b1);
      wait_li(8, "lat_after_rst", lat);
      chk("lat_after_rst", 32'(lat), 32'd8);
      @(posedge clk); #1;

      nb = nli8;
      @(negedge clk);
      a8 = 8'hC3; b8 = 8'h5A; ini8 = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         if ((k - 1) % 10 == 0) q8.push_back(ref8(8'hC3, 8'h5A));
         @(posedge clk); #1;
         if (li8) pk.push_back(k);
      end
      @(negedge clk) ini8 = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("b2b_count", 32'(pk.size()), 32'd3);
      for (int i = 0; i < pk.size() && i < 3; i++)
         chk("b2b_pos", 32'(pk[i]), 32'(9 + 10 * i));
      chk("b2b_pulses", 32'(nli8 - nb), 32'd3);

      fork
         begin
            int l1;
            for (int i = 0; i < 1000; i++) begin
               go1(1'($urandom), 1'($urandom));
               wait_li(1, "lat1", l1);
               chk("lat1", 32'(l1), 32'd1);
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
         end
         begin
            int l16;
            for (int i = 0; i < 1000; i++) begin
               go16(16'($urandom), 16'($urandom));
               wait_li(16, "lat16", l16);
               chk("lat16", 32'(l16), 32'd16);
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
         end
      join

      repeat (4) @(posedge clk);
      #1;
      chk("q8_empty", 32'(q8.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      chk("q16_empty", 32'(q16.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: got no end of run expected finish");
      $fatal(1, "timeout");
   end
endmodule
